sincos_sched: RTL and testbench
===============================

SINCOS_SCHED -- requirements
Module: sincos_sched

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  4  per-requester burst request, level.
- req_fsel  in  8  2-bit frequency select per requester; bits [2i+1:2i] belong to requester i.
- grant  out  4  one-hot owner of the generator.
- burst_id  out  2  index of the current owner.
- busy  out  1  a burst is in progress.
- gen_rst  out  1  drives the generator's synchronous reset.
- gen_fsel  out  2  drives the generator's frequency select.
- gen_done  in  1  the generator's done flag.
- sample_valid  out  1  the generator's sin/cos outputs carry a new sample this cycle.
- sample_cnt  out  11  samples delivered in the current burst.
- timeout_err  out  1  one-cycle pulse when a burst is aborted.

Function
REQ-002 SHALL implement the FSM IDLE -> ARB -> LOAD -> RUN -> RELEASE -> IDLE, one state per cycle except RUN.
REQ-003 IDLE SHALL go to ARB when req != 0; otherwise it stays in IDLE.
REQ-004 ARB SHALL choose a requester round-robin:
- Search starts at rr_ptr and wraps 3 -> 0.
- Winner is the first index with req set.
- At the edge leaving ARB, grant, burst_id, gen_fsel = req_fsel[winner] and rr_ptr = winner+1 mod 4 SHALL register together.
REQ-005 If req drops to 0 while in ARB, the FSM SHALL return to IDLE with no grant and rr_ptr unchanged.
REQ-006 gen_rst SHALL be 1 in IDLE, ARB, LOAD and RELEASE, and 0 only in RUN.
REQ-007 gen_fsel SHALL be stable during LOAD, so the generator latches its step from it.
REQ-008 grant SHALL become one-hot in LOAD and be held until the RELEASE->IDLE edge. Bursts are non-preemptive: the owner dropping req mid-burst SHALL NOT shorten the burst.
REQ-009 busy SHALL be 1 in LOAD, RUN and RELEASE.
REQ-010 sample_valid SHALL be 1 for exactly 1024 consecutive cycles, starting on the 2nd RUN cycle (RUN cycles 2..1025).
REQ-011 sample_cnt SHALL clear on entering LOAD and increment on each sample_valid cycle, saturating at 1024.
REQ-012 RUN SHALL exit to RELEASE on the first cycle gen_done = 1 (nominally RUN cycle 1026).
REQ-013 gen_done = 1 outside RUN SHALL be ignored.
REQ-014 Requests arriving in LOAD, RUN or RELEASE SHALL be held off; they are arbitrated on the next ARB.
REQ-015 Latency: req sampled in IDLE at cycle 0 SHALL give grant at cycle 2 and gen_rst = 0 at cycle 3.

Reset
REQ-016 rst SHALL, at the next edge in any state, do all of the following:
- Force IDLE.
- Clear grant, burst_id, gen_fsel, busy, sample_valid, sample_cnt and timeout_err.
- Set rr_ptr to 0.
- Set gen_rst = 1.
REQ-017 A reset mid-burst SHALL abandon the burst, emit no timeout_err, and leave no grant after the reset edge.

Configuration
REQ-018 Macro SINCOS_SCHED_TIMEOUT_EN SHALL select the watchdog.
- Defined: a 12-bit RUN-cycle counter runs. If gen_done is not seen by RUN cycle 1100, the FSM SHALL go to RELEASE and pulse timeout_err for one cycle, in RELEASE.
- Undefined: RUN waits for gen_done indefinitely, and timeout_err SHALL be constant 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single request: req=0001, fsel0=2 from reset -> grant=0001 at cycle 2, gen_fsel=2, 1024 sample_valid pulses, sample_cnt=1024, grant clears 2 cycles after gen_done.
- Round-robin: req=1111 held over four bursts -> owners in order 0,1,2,3, then 0 again.
- Non-preemption: owner 2 drops req at RUN cycle 10 while req1 is asserted -> burst 2 still delivers 1024 samples, next grant=0010.
- Mid-burst reset: rst at RUN cycle 500 -> next cycle grant=0, busy=0, gen_rst=1, sample_cnt=0, rr_ptr=0.
- Watchdog (macro defined): gen_done held 0 -> timeout_err pulses once, in the RELEASE cycle after RUN cycle 1100; with the macro undefined the FSM stays in RUN and timeout_err=0.
- Stray done: gen_done=1 in IDLE with req=0 -> no state change, no outputs toggle.

Source files
------------

// File: rtl/sincos_sched.sv
// Round-robin scheduler granting a shared sin/cos generator to one of four requesters
// for fixed 1024-sample bursts. Optional watchdog enabled by SINCOS_SCHED_TIMEOUT_EN.
module sincos_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [7:0]  req_fsel,
  output logic [3:0]  grant,
  output logic [1:0]  burst_id,
  output logic        busy,
  output logic        gen_rst,
  output logic [1:0]  gen_fsel,
  input  logic        gen_done,
  output logic        sample_valid,
  output logic [10:0] sample_cnt,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_rr_ptr;
  logic [11:0] r_run_cnt;
  logic [3:0]  r_grant;
  logic [1:0]  r_burst_id;
  logic        r_busy;
  logic        r_gen_rst;
  logic [1:0]  r_gen_fsel;
  logic        r_sample_valid;
  logic [10:0] r_sample_cnt;
`ifdef SINCOS_SCHED_TIMEOUT_EN
  logic        r_timeout_err;
`endif

  logic [1:0]  w_winner;
  logic [1:0]  w_idx;
  logic        w_any;
  logic [1:0]  w_win_fsel;

  // First requester at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    w_winner = '0;
    w_idx    = '0;
    w_any    = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_any && req[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
    w_win_fsel = req_fsel[{w_winner, 1'b0} +: 2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_run_cnt      <= '0;
      r_grant        <= '0;
      r_burst_id     <= '0;
      r_busy         <= 1'b0;
      r_gen_rst      <= 1'b1;
      r_gen_fsel     <= '0;
      r_sample_valid <= 1'b0;
      r_sample_cnt   <= '0;
`ifdef SINCOS_SCHED_TIMEOUT_EN
      r_timeout_err  <= 1'b0;
`endif
    end else begin
`ifdef SINCOS_SCHED_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      if (r_sample_valid && r_sample_cnt != 11'd1024)
        r_sample_cnt <= r_sample_cnt + 11'd1;

      case (r_state)
        S_IDLE: begin
          if (req != '0)
            r_state <= S_ARB;
        end
        S_ARB: begin
          if (!w_any) begin
            r_state <= S_IDLE;
          end else begin
            r_state      <= S_LOAD;
            r_grant      <= 4'b0001 << w_winner;
            r_burst_id   <= w_winner;
            r_gen_fsel   <= w_win_fsel;
            r_rr_ptr     <= w_winner + 2'd1;
            r_busy       <= 1'b1;
            r_sample_cnt <= '0;
          end
        end
        S_LOAD: begin
          r_state   <= S_RUN;
          r_gen_rst <= 1'b0;
          r_run_cnt <= 12'd1;
        end
        S_RUN: begin
          if (gen_done) begin
            r_state        <= S_RELEASE;
            r_gen_rst      <= 1'b1;
            r_sample_valid <= 1'b0;
          end
`ifdef SINCOS_SCHED_TIMEOUT_EN
          else if (r_run_cnt == 12'd1100) begin
            r_state        <= S_RELEASE;
            r_gen_rst      <= 1'b1;
            r_sample_valid <= 1'b0;
            r_timeout_err  <= 1'b1;
          end
`endif
          else begin
            // r_run_cnt is the current RUN cycle; valid is registered for the next one (2..1025).
            r_sample_valid <= (r_run_cnt <= 12'd1024);
            if (r_run_cnt != '1)
              r_run_cnt <= r_run_cnt + 12'd1;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant        = r_grant;
  assign burst_id     = r_burst_id;
  assign busy         = r_busy;
  assign gen_rst      = r_gen_rst;
  assign gen_fsel     = r_gen_fsel;
  assign sample_valid = r_sample_valid;
  assign sample_cnt   = r_sample_cnt;
`ifdef SINCOS_SCHED_TIMEOUT_EN
  assign timeout_err  = r_timeout_err;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sincos_sched.sv
// Self-checking bench for sincos_sched: directed scenarios plus randomized bursts
// checked against a burst-level reference model.
module tb_sincos_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  req_fsel;
  logic [3:0]  grant;
  logic [1:0]  burst_id;
  logic        busy;
  logic        gen_rst;
  logic [1:0]  gen_fsel;
  logic        gen_done;
  logic        sample_valid;
  logic [10:0] sample_cnt;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  sincos_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_fsel     (req_fsel),
    .grant        (grant),
    .burst_id     (burst_id),
    .busy         (busy),
    .gen_rst      (gen_rst),
    .gen_fsel     (gen_fsel),
    .gen_done     (gen_done),
    .sample_valid (sample_valid),
    .sample_cnt   (sample_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gen_rst"}, gen_rst, 1);
    chk({tag, "_sample_cnt"}, sample_cnt, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_timeout"}, timeout_err, 0);
  endtask

  // One burst from an IDLE cycle: model predicts owner, sample window, exit and timeout.
  task automatic burst(input logic [3:0] reqv, input logic [7:0] fselv, input int done_at,
                       input int drop_at, input logic [3:0] dropmask, input int rst_at);
    int w, fs, exit_k, nbad, nvalid, exp_cnt;
    logic to_exp;
    w  = pick(reqv, m_ptr);
    fs = (fselv >> (2 * w)) & 3;
    exit_k = done_at;
    to_exp = 1'b0;
`ifdef SINCOS_SCHED_TIMEOUT_EN
    if (done_at > 1100) begin
      exit_k = 1100;
      to_exp = 1'b1;
    end
`endif
    req = reqv; req_fsel = fselv; gen_done = 1'b0;
    step();
    chk("arb_grant", grant, 0);
    chk("arb_busy", busy, 0);
    chk("arb_gen_rst", gen_rst, 1);
    step();
    chk("load_grant", grant, 32'(1) << w);
    chk("load_burst_id", burst_id, w);
    chk("load_gen_fsel", gen_fsel, fs);
    chk("load_busy", busy, 1);
    chk("load_gen_rst", gen_rst, 1);
    chk("load_sample_cnt", sample_cnt, 0);
    m_ptr = (w + 1) % 4;
    step();
    chk("run1_gen_rst", gen_rst, 0);
    nbad = 0; nvalid = 0;
    for (int k = 1; k <= 1300; k++) begin
      if (k == drop_at) req = req & ~dropmask;
      if (sample_valid !== (k >= 2 && k <= 1025)) nbad++;
      if (sample_valid === 1'b1) nvalid++;
      if (gen_rst !== 1'b0 || grant !== (4'b0001 << w) || busy !== 1'b1 || timeout_err !== 1'b0) nbad++;
      if (k == rst_at) begin
        chk("run_pattern", nbad, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("midrst");
        m_ptr = 0;
        return;
      end
      gen_done = (k == done_at);
      if (k == exit_k) break;
      step();
    end
    exp_cnt = (exit_k < 1025 ? exit_k : 1025) - 1;
    if (exp_cnt < 0) exp_cnt = 0;
    chk("run_pattern", nbad, 0);
    chk("run_valid_pulses", nvalid, exp_cnt);
    step();
    gen_done = 1'b0;
    chk("rel_gen_rst", gen_rst, 1);
    chk("rel_busy", busy, 1);
    chk("rel_grant", grant, 32'(1) << w);
    chk("rel_sample_valid", sample_valid, 0);
    chk("rel_sample_cnt", sample_cnt, exp_cnt);
    chk("rel_timeout", timeout_err, to_exp);
    step();
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);
    chk("idle_timeout", timeout_err, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_fsel = '0; gen_done = 1'b0;
    step();
    step();
    chk_reset_state("reset");
    chk("reset_burst_id", burst_id, 0);
    chk("reset_gen_fsel", gen_fsel, 0);
    rst = 1'b0;

    // Stray done in IDLE must change nothing.
    gen_done = 1'b1;
    repeat (3) step();
    chk_reset_state("stray");
    gen_done = 1'b0;

    // Single request, fsel0 = 2, nominal done at RUN cycle 1026.
    burst(4'b0001, 8'h02, 1026, 0, 4'b0000, 0);

    // Round robin with all four held: m_ptr is 1 here, so owners 1,2,3,0,1.
    m_ptr = 1;
    for (int b = 0; b < 5; b++)
      burst(4'b1111, 8'b11_10_01_00, 1026, 0, 4'b0000, 0);

    // Non-preemption: owner 2 drops at RUN cycle 10 while req1 stays up.
    burst(4'b0110, 8'b00_10_11_00, 1026, 10, 4'b0100, 0);
    burst(4'b0010, 8'b00_00_01_00, 1026, 0, 4'b0000, 0);

    // Request vanishes in ARB: back to IDLE, no grant, pointer untouched.
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    chk("arbdrop_grant", grant, 0);
    chk("arbdrop_busy", busy, 0);
    step();
    chk("arbdrop_idle_busy", busy, 0);
    burst(4'b1111, 8'h1b, 1026, 0, 4'b0000, 0);

    // Mid-burst reset at RUN cycle 500, then pointer must restart at 0.
    burst(4'b0010, 8'h55, 1026, 0, 4'b0000, 500);
    burst(4'b1111, 8'h9c, 1026, 0, 4'b0000, 0);

`ifdef SINCOS_SCHED_TIMEOUT_EN
    burst(4'b1000, 8'hc0, 99999, 0, 4'b0000, 0);
`else
    burst(4'b1000, 8'hc0, 99999, 0, 4'b0000, 1200);
`endif

    for (int b = 0; b < 4; b++)
      burst(4'($urandom_range(1, 15)), 8'($urandom), $urandom_range(1020, 1030), 0, 4'b0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
